// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MDU       = 2'd1,
        EXC_FLUSH = 2'd2
    } state_t;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/mdu_occ_timer.sv
// Down-counter tracking remaining mult/div occupancy cycles in EX.
// Priority: clear, load, decrement; otherwise the count is frozen.
module mdu_occ_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline registers.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic             e_mem_read,
    input  logic [REG_W-1:0] e_wreg,
    input  logic             e_mdu_start,
    input  logic             mem_stall,
    input  logic             m_exception,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             clear_d,
    output logic             clear_e,
    output logic             clear_m,
    output logic             clear_w,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [31:0]      perf_stall_cnt
);

    localparam logic [CNT_W-1:0] MDU_LOAD = CNT_W'(MDU_CYCLES - 2);

    state_t           state, state_nxt;
    logic             t_clr, t_load, t_dec, t_zero;
    logic [CNT_W-1:0] t_cnt;
    logic             load_use;

    mdu_occ_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (t_clr),
        .load     (t_load),
        .load_val (MDU_LOAD),
        .dec      (t_dec),
        .cnt      (t_cnt),
        .zero     (t_zero)
    );

    assign load_use = e_mem_read && (e_wreg != ZERO_REG) &&
                      ((d_uses_rs && d_rs == e_wreg) || (d_uses_rt && d_rt == e_wreg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        t_clr     = 1'b0;
        t_load    = 1'b0;
        t_dec     = 1'b0;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        clear_d   = 1'b0;
        clear_e   = 1'b0;
        clear_m   = 1'b0;
        clear_w   = 1'b0;
        mdu_busy  = 1'b0;
        mdu_done  = 1'b0;
        // Outputs are forced low for the whole time reset is held.
        if (!rst) begin
            if (state == EXC_FLUSH) begin
                clear_d   = 1'b1;
                state_nxt = RUN;
            end else if (m_exception) begin
                {clear_d, clear_e, clear_m, clear_w} = 4'b1111;
                mdu_busy  = (state == MDU);
                t_clr     = 1'b1;
                state_nxt = EXC_FLUSH;
            end else if (mem_stall) begin
                {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
                clear_w  = 1'b1;
                mdu_busy = (state == MDU);
            end else if (state == MDU) begin
                mdu_busy = 1'b1;
                if (t_zero) begin
                    mdu_done  = 1'b1;
                    state_nxt = RUN;
                end else begin
                    {stall_f, stall_d, stall_e} = 3'b111;
                    clear_m = 1'b1;
                    t_dec   = 1'b1;
                end
            end else if (e_mdu_start) begin
                {stall_f, stall_d, stall_e} = 3'b111;
                clear_m   = 1'b1;
                mdu_busy  = 1'b1;
                t_load    = 1'b1;
                state_nxt = MDU;
            end else if (load_use) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                clear_e = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= '0;
        end else if (stall_f && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule
